// File: rtl/exe_div.sv
// rtl/exe_div.sv - multi-cycle 32-bit signed/unsigned restoring divider for the EXE stage
module exe_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    input  logic        advance_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] q, q_nx, d, d_nx;
    // The partial remainder is always below the divisor, so 32 bits of it are enough.
    logic [31:0] r, r_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        q_neg, q_neg_nx, r_neg, r_neg_nx;
    logic [31:0] quot_nx, rem_nx;
    logic [32:0] t, diff;
    logic [31:0] q_step, r_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            state       <= state_nx;
            q           <= q_nx;
            d           <= d_nx;
            r           <= r_nx;
            cnt         <= cnt_nx;
            q_neg       <= q_neg_nx;
            r_neg       <= r_neg_nx;
            quotient_o  <= quot_nx;
            remainder_o <= rem_nx;
        end
    end

    always_comb begin
        t        = {r, q[31]};
        diff     = t - {1'b0, d};
        q_step   = diff[32] ? {q[30:0], 1'b0} : {q[30:0], 1'b1};
        r_step   = diff[32] ? t[31:0] : diff[31:0];

        state_nx = state;
        q_nx     = q;
        d_nx     = d;
        r_nx     = r;
        cnt_nx   = cnt;
        q_neg_nx = q_neg;
        r_neg_nx = r_neg;
        quot_nx  = quotient_o;
        rem_nx   = remainder_o;

        if (cancel_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == 32'd0) begin
                            quot_nx  = '0;
                            rem_nx   = '0;
                            state_nx = DONE;
                        end else begin
                            q_nx     = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
                            d_nx     = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
                            r_nx     = '0;
                            cnt_nx   = '0;
                            q_neg_nx = signed_i & (dividend_i[31] ^ divisor_i[31]);
                            r_neg_nx = signed_i & dividend_i[31];
                            state_nx = BUSY;
                        end
                    end
                end
                BUSY: begin
                    q_nx   = q_step;
                    r_nx   = r_step;
                    cnt_nx = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        quot_nx  = q_neg ? -q_step : q_step;
                        rem_nx   = r_neg ? -r_step : r_step;
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    if (advance_i) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign done_o      = (state == DONE);
    assign stall_req_o = rst & ~cancel_i & (((state == IDLE) & start_i) | (state == BUSY));

endmodule

// File: tb/tb_exe_div.sv
// tb/tb_exe_div.sv - self-checking bench for exe_div
module tb_exe_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        cancel_i = 1'b0;
    logic        advance_i = 1'b0;
    logic [31:0] quotient_o, remainder_o;
    logic        done_o, stall_req_o;

    int total = 0;
    int bad = 0;

    exe_div dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .cancel_i(cancel_i),
        .advance_i(advance_i), .quotient_o(quotient_o), .remainder_o(remainder_o),
        .done_o(done_o), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: integer division truncating toward zero, remainder takes the dividend's sign.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
        end
    endfunction

    task automatic do_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int hold);
        int n, stalls;
        int elat;
        elat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b; advance_i = 1'b0;
        #1;
        n = 0;
        stalls = stall_req_o ? 1 : 0;
        while (!done_o && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (stall_req_o) stalls++;
        end
        chk({name, " latency"}, n, elat);
        chk({name, " stall cycles"}, stalls, elat);
        chk({name, " quotient"}, quotient_o, eq);
        chk({name, " remainder"}, remainder_o, er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk({name, " hold done"}, done_o, 1);
            chk({name, " hold stall"}, stall_req_o, 0);
            chk({name, " hold quotient"}, quotient_o, eq);
            chk({name, " hold remainder"}, remainder_o, er);
        end
        start_i = 1'b0; advance_i = 1'b1;
        @(negedge clk);
        advance_i = 1'b0;
        #1;
        chk({name, " done after advance"}, done_o, 0);
    endtask

    initial begin
        logic [31:0] rq, rr, ra, rb;
        logic        rs;
        int          seen;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
        tbl[2] = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001};
        tbl[3] = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'h0000_0000,  32'h0000_0000};
        tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  32'h0000_000F};
        tbl[7] = '{1'b0, 32'h0000_0005,  32'hFFFF_FFFF,  32'h0000_0000,  32'h0000_0005};

        start_i = 1'b1;
        #12;
        chk("reset quotient", quotient_o, 0);
        chk("reset remainder", remainder_o, 0);
        chk("reset done", done_o, 0);
        chk("reset stall", stall_req_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            do_div($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 0);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = $urandom;
                2: rb = 32'd0;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(rs, ra, rb, rq, rr);
            do_div($sformatf("rand%0d", i), rs, ra, rb, rq, rr, 0);
        end

        // Cancel in BUSY cycle 10 must drop stall at once and leave the old result.
        do_div("pre-cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'h1234_5678; divisor_i = 32'd3;
        for (int i = 0; i < 10; i++) @(negedge clk);
        cancel_i = 1'b1;
        #1;
        chk("cancel stall", stall_req_o, 0);
        @(negedge clk);
        cancel_i = 1'b0; start_i = 1'b0;
        #1;
        chk("cancel idle stall", stall_req_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_o) seen++;
        end
        chk("cancel done seen", seen, 0);
        chk("cancel quotient kept", quotient_o, 14);
        chk("cancel remainder kept", remainder_o, 2);

        // DONE held with start high, then a fresh divide after advance.
        do_div("hold", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 3);
        do_div("after-hold", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0);

        // Asynchronous reset in BUSY cycle 5.
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'h10;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset quotient", quotient_o, 0);
        chk("midreset remainder", remainder_o, 0);
        chk("midreset done", done_o, 0);
        chk("midreset stall", stall_req_o, 0);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        do_div("post-reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_div.md
# exe_div

Multi-cycle 32-bit signed/unsigned divider for the EXE stage, fed by the ID→EXE pipeline register's operand and opcode outputs. It produces the quotient (LO) and remainder (HI) for DIV/DIVU. While a division is in flight it raises a stall request, so the ID→EXE register holds its contents. A flush from the exception path cancels an in-flight division.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start_i  input  1  EXE holds a DIV/DIVU (EXE gates this with the opcode); held high by the stalled ID→EXE register.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend_i  input  32  exe_reg1 value; sampled with start.
- divisor_i  input  32  exe_reg2 value; sampled with start.
- cancel_i  input  1  pipeline flush; aborts the division.
- advance_i  input  1  EXE→MEM handoff occurred this cycle (EXE not stalled by any source).
- quotient_o  output  32  result for LO.
- remainder_o  output  32  result for HI.
- done_o  output  1  results valid.
- stall_req_o  output  1  stall request to pipeline control.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, start_i=1, cancel_i=0, divisor_i≠0:
  - Load |dividend| into the quotient shift register q[31:0].
  - Load |divisor| into d[31:0] (magnitude only when signed_i=1).
  - Clear partial remainder r[32:0] and cnt[4:0].
  - Latch signed_i, the sign of the quotient (dividend[31]^divisor[31]) and the sign of the remainder (dividend[31]).
  - Next state BUSY.
- IDLE, start_i=1, cancel_i=0, divisor_i=0: quotient_o=0, remainder_o=0, next state DONE (divide-by-zero shortcut).
- BUSY, one restoring step per cycle:
  - t = {r[31:0], q[31]} (33 bits); diff = t − {1'b0, d}.
  - If diff[32]=0: r=diff, q={q[30:0],1}.
  - Otherwise: r=t, q={q[30:0],0}.
  - cnt increments after each step.
- BUSY with cnt==31: the step completes, then sign correction (signed only):
  - quotient_o = quotient sign ? −q : q.
  - remainder_o = remainder sign ? −r[31:0] : r[31:0].
  - Next state DONE.
- DONE: done_o=1; outputs held. advance_i=1 → IDLE.
- cancel_i=1 in any state: next state IDLE, done_o deasserted, quotient_o/remainder_o keep their old values. cancel_i has priority over start_i and advance_i in the same cycle.
- 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0 (magnitude arithmetic wraps naturally).
- Results persist in quotient_o/remainder_o until the next completed division; they are meaningful only while done_o=1.

## Timing
- Reset (rst=0, asynchronous): state IDLE, quotient_o=0, remainder_o=0, done_o=0, cnt=0, r=0, q=0, d=0. stall_req_o is forced 0 while rst=0.
- stall_req_o is combinational:
  - (IDLE & start_i & ~cancel_i) | BUSY.
  - It is 0 in DONE and 0 whenever cancel_i=1.
- Normal latency: start sampled in cycle 0 → BUSY in cycles 1..32 → done_o=1 from cycle 33. stall_req_o is high in cycles 0..32 (33 cycles).
- Divide-by-zero: stall_req_o high in cycle 0 only; done_o=1 from cycle 1.
- done_o stays high while advance_i=0, with no restart even though start_i remains high.
- Back-to-back divides: DONE→IDLE on advance_i. The next instruction's start_i is sampled in the following cycle, so a new division starts then.
- Reset mid-BUSY: immediate return to IDLE with all outputs at reset values.

## Test plan
- Unsigned 100 / 7:
  - stall_req_o=1 for 33 cycles.
  - Cycle 33: done_o=1, quotient_o=14, remainder_o=2.
  - One cycle after advance_i=1: done_o=0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002):
  - quotient_o=0xFFFFFFFD.
  - remainder_o=0xFFFFFFFF.
  - Signed 7 / −2: quotient_o=0xFFFFFFFD, remainder_o=0x00000001.
- Divisor 0 (e.g. 0x12345678 / 0):
  - stall_req_o=1 for one cycle.
  - Cycle 1: done_o=1, quotient_o=0, remainder_o=0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient_o=0x80000000, remainder_o=0. Unsigned 0xFFFFFFFF / 1 → quotient_o=0xFFFFFFFF, remainder_o=0.
- cancel_i=1 in BUSY cycle 10:
  - stall_req_o=0 in that cycle; IDLE next cycle.
  - done_o never asserts.
  - Outputs keep the previous result.
- DONE held with advance_i=0 for 3 cycles and start_i=1: no restart, outputs stable. Then advance_i=1, followed by a new start (0xFFFFFFFF / 0x10 unsigned) → quotient_o=0x0FFFFFFF, remainder_o=0xF after 33 more cycles. Repeat with rst pulsed low in BUSY cycle 5 → all outputs zero immediately.
